// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin req/gnt arbiter: registered one-hot grant, hold limit with
// preempt pulse, and a one-cycle gap between successive grants.
module rr_req_gnt_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               preempt
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               preempt_q, preempt_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic               at_limit;
    logic               others_req;

    // Search starts just after the last winner, so it has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!win_found && req[(int'(last_id_q) + i) % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(last_id_q) + i) % NUM_REQ);
            end
        end
    end

    assign at_limit   = (hold_cnt_q == CNT_W'(MAX_HOLD));
    assign others_req = |(req & ~gnt_q);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        preempt_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_id_d   = last_id_q;
        case (state_q)
            IDLE, GAP: begin
                if (win_found) begin
                    state_d        = GRANT;
                    gnt_d          = '0;
                    gnt_d[win_id]  = 1'b1;
                    gnt_valid_d    = 1'b1;
                    gnt_id_d       = win_id;
                    hold_cnt_d     = CNT_W'(1);
                    last_id_d      = win_id;
                end else begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                // Release takes priority over the limit, so no preempt then.
                if (!req[gnt_id_q] || (at_limit && others_req)) begin
                    state_d     = GAP;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    hold_cnt_d  = '0;
                    preempt_d   = req[gnt_id_q];
                end else if (!at_limit) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_id_d    = '0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            preempt_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_id_q   <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            preempt_q   <= preempt_d;
            hold_cnt_q  <= hold_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Directed bench: driver queues hand-computed expectations after each edge,
// a negedge monitor pops and compares against the arbiter outputs.
module tb_rr_req_gnt_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 8;

    logic               clk;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [1:0]         gnt_id;
    logic               preempt;

    typedef struct {
        logic [NUM_REQ-1:0] gnt;
        logic               pre;
        string              tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    rr_req_gnt_arbiter #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt),
        .gnt_valid(gnt_valid), .gnt_id(gnt_id), .preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] idx_of(input logic [NUM_REQ-1:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check(input logic [NUM_REQ-1:0] eg, input logic ep, input string tag);
        logic       ev;
        logic [1:0] ei;
        ev = |eg;
        ei = idx_of(eg);
        n_cmp++;
        if (gnt !== eg || gnt_valid !== ev || gnt_id !== ei || preempt !== ep) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b valid=%b id=%0d preempt=%b, want gnt=%b valid=%b id=%0d preempt=%b",
                     tag, gnt, gnt_valid, gnt_id, preempt, eg, ev, ei, ep);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.gnt, e.pre, e.tag);
            n_cmp++;
            if (!$onehot0(gnt)) begin
                n_bad++;
                $display("FAIL onehot0: got gnt=%b, want at most one bit", gnt);
            end
        end
    end

    // Drive req for the coming edge (called at a negedge), queue what must follow it.
    task automatic step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] eg,
                        input logic ep, input string tag);
        exp_t e;
        req = r;
        @(posedge clk);
        #1;
        e.gnt = eg; e.pre = ep; e.tag = tag;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        #1;
        check(4'b0000, 1'b0, "reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(4'b0000, 1'b0, "reset_held_req");
        reset = 1'b0;

        // Full contention: 8-cycle grants 0,1,2,3,0 with preempting gaps.
        step(4'b1111, 4'b0001, 1'b0, "first_after_reset");
        repeat (MAX_HOLD - 1) step(4'b1111, 4'b0001, 1'b0, "contend_own0");
        for (int k = 1; k <= 4; k++) begin
            logic [NUM_REQ-1:0] g;
            g = 4'b0001 << (k % 4);
            step(4'b1111, 4'b0000, 1'b1, "contend_gap");
            repeat (MAX_HOLD) step(4'b1111, g, 1'b0, "contend_own");
        end
        step(4'b0000, 4'b0000, 1'b0, "contend_release");
        step(4'b0000, 4'b0000, 1'b0, "contend_idle");

        // Single requester, released at edge 4.
        repeat (3) step(4'b0100, 4'b0100, 1'b0, "single_grant");
        step(4'b0000, 4'b0000, 1'b0, "single_release");
        step(4'b0000, 4'b0000, 1'b0, "single_idle");
        step(4'b0000, 4'b0000, 1'b0, "single_idle2");

        // Sole long holder saturates, then a competitor preempts.
        repeat (20) step(4'b0010, 4'b0010, 1'b0, "sole_hold");
        step(4'b1010, 4'b0000, 1'b1, "sole_preempt");
        step(4'b1010, 4'b1000, 1'b0, "sole_next");
        step(4'b0000, 4'b0000, 1'b0, "sole_release");
        step(4'b0000, 4'b0000, 1'b0, "sole_idle");

        // Release on the 8th cycle beats the limit: no preempt.
        repeat (MAX_HOLD) step(4'b0101, 4'b0001, 1'b0, "rel_limit_own0");
        step(4'b0100, 4'b0000, 1'b0, "rel_limit_gap");
        step(4'b0100, 4'b0100, 1'b0, "rel_limit_next");
        step(4'b0000, 4'b0000, 1'b0, "rel_limit_release");
        step(4'b0000, 4'b0000, 1'b0, "rel_limit_idle");

        // Asynchronous reset while requester 3 owns the grant.
        step(4'b1000, 4'b1000, 1'b0, "pre_reset_grant");
        step(4'b1000, 4'b1000, 1'b0, "pre_reset_hold");
        #2;
        reset = 1'b1;
        #1;
        check(4'b0000, 1'b0, "async_reset_drop");
        @(posedge clk);
        @(negedge clk);
        check(4'b0000, 1'b0, "in_reset");
        req   = 4'b1001;
        reset = 1'b0;
        step(4'b1001, 4'b0001, 1'b0, "post_reset_first");
        step(4'b1001, 4'b0001, 1'b0, "post_reset_hold");
        step(4'b0000, 4'b0000, 1'b0, "post_reset_release");
        step(4'b0000, 4'b0000, 1'b0, "post_reset_idle");

        @(posedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
